// File: rtl/slv_guard_cfg_pkg.sv
// Shared types and constants for the slave-guard configuration sequencer.
package slv_guard_cfg_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  localparam logic [AddrWidth-1:0] EnableOffset = AddrWidth'(32'h0);
  localparam logic [AddrWidth-1:0] BudgetOffset = AddrWidth'(32'h4);
  localparam logic [AddrWidth-1:0] RegStride    = AddrWidth'(32'h4);

  localparam int unsigned          DefaultNumBudgets = 10;
  localparam logic [DataWidth-1:0] DefaultBudget     = 32'h0000_0100;
  localparam logic [DataWidth-1:0] DefaultEnable     = 32'h0000_0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BUS      = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_MISMATCH = 2'd3
  } err_code_e;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [DataWidth-1:0] wdata;
    logic [StrbWidth-1:0] wstrb;
    logic                 valid;
  } reg_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 error;
    logic                 ready;
  } reg_rsp_t;

  // Index 0 is the enable register; index k>0 is budget k-1.
  function automatic logic [AddrWidth-1:0] reg_addr(input logic [AddrWidth-1:0] base,
                                                    input logic [31:0]          idx);
    if (idx == 32'd0) return base + EnableOffset;
    return base + BudgetOffset + AddrWidth'((idx - 32'd1) * 32'(RegStride));
  endfunction

endpackage

// File: rtl/slv_guard_cfg_timeout.sv
// Response wait counter: clears on request or ready, flags expiry on the last allowed cycle.
module slv_guard_cfg_timeout
  import slv_guard_cfg_pkg::*;
#(
  parameter int unsigned RspTimeout = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clr,
  input  logic i_cnt,
  output logic o_expire_c
);

  localparam int unsigned CntW = $clog2(RspTimeout + 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || i_clr) begin
      r_cnt <= '0;
    end else if (i_cnt && !o_expire_c) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign o_expire_c = i_cnt && (r_cnt == CntW'(RspTimeout - 1));

endmodule

// File: rtl/slv_guard_cfg_seq.sv
// Reg-bus initiator that programs the slave guard: budgets first, enable last,
// with optional read-back verification and error reporting.
module slv_guard_cfg_seq
  import slv_guard_cfg_pkg::*;
#(
  parameter int unsigned          NumBudgets = DefaultNumBudgets,
  parameter logic [AddrWidth-1:0] BaseAddr   = '0,
  parameter bit                   VerifyEn   = 1'b1,
  parameter int unsigned          RspTimeout = 16,
  localparam int unsigned         IdxW       = $clog2(NumBudgets + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic [DataWidth-1:0]            enable_i,
  input  logic [DataWidth*NumBudgets-1:0] budgets_i,
  output reg_req_t                        reg_req_o,
  input  reg_rsp_t                        reg_rsp_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            error_o,
  output logic [IdxW-1:0]                 err_idx_o,
  output logic [1:0]                      err_code_o
);

  state_e               r_state;
  reg_req_t             r_req;
  logic [IdxW-1:0]      r_idx;
  logic [DataWidth-1:0] r_shadow [NumBudgets+1];
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;
  logic [IdxW-1:0]      r_err_idx;
  err_code_e            r_err_code;

  logic                 w_tmo_cnt;
  logic                 w_tmo_clr;
  logic                 w_expire_c;
  logic [AddrWidth-1:0] w_addr;
  logic [DataWidth-1:0] w_shadow;
  logic                 w_last_idx;
  logic [IdxW-1:0]      w_idx_next;

  assign w_tmo_cnt  = r_req.valid && !reg_rsp_i.ready;
  assign w_tmo_clr  = !w_tmo_cnt;
  assign w_addr     = reg_addr(BaseAddr, 32'(r_idx));
  assign w_shadow   = r_shadow[r_idx];
  assign w_last_idx = (r_idx == IdxW'(NumBudgets));
  assign w_idx_next = w_last_idx ? '0 : r_idx + IdxW'(1);

  slv_guard_cfg_timeout #(
    .RspTimeout (RspTimeout)
  ) u_timeout (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_clr      (w_tmo_clr),
    .i_cnt      (w_tmo_cnt),
    .o_expire_c (w_expire_c)
  );

  // Each transaction: request issued one cycle, held until ready, then one idle cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_req      <= '0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_idx  <= '0;
      r_err_code <= ERR_NONE;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_shadow[0] <= enable_i;
            for (int k = 0; k < int'(NumBudgets); k++) begin
              r_shadow[k+1] <= budgets_i[DataWidth*k +: DataWidth];
            end
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            r_busy     <= 1'b1;
            r_idx      <= IdxW'(1);
            r_state    <= ST_WR;
          end
        end
        ST_WR: begin
          if (!r_req.valid) begin
            r_req.addr  <= w_addr;
            r_req.write <= 1'b1;
            r_req.wdata <= w_shadow;
            r_req.wstrb <= '1;
            r_req.valid <= 1'b1;
          end else if (reg_rsp_i.ready) begin
            r_req <= '0;
            if (reg_rsp_i.error) begin
              r_state    <= ST_ERR;
              r_error    <= 1'b1;
              r_err_idx  <= r_idx;
              r_err_code <= ERR_BUS;
            end else if (VerifyEn) begin
              r_state <= ST_RD;
            end else if (r_idx == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx <= w_idx_next;
            end
          end else if (w_expire_c) begin
            r_req      <= '0;
            r_state    <= ST_ERR;
            r_error    <= 1'b1;
            r_err_idx  <= r_idx;
            r_err_code <= ERR_TIMEOUT;
          end
        end
        ST_RD: begin
          if (!r_req.valid) begin
            r_req.addr  <= w_addr;
            r_req.write <= 1'b0;
            r_req.wdata <= '0;
            r_req.wstrb <= '0;
            r_req.valid <= 1'b1;
          end else if (reg_rsp_i.ready) begin
            r_req <= '0;
            if (reg_rsp_i.error || (reg_rsp_i.rdata != w_shadow)) begin
              r_state    <= ST_ERR;
              r_error    <= 1'b1;
              r_err_idx  <= r_idx;
              r_err_code <= reg_rsp_i.error ? ERR_BUS : ERR_MISMATCH;
            end else if (r_idx == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= w_idx_next;
              r_state <= ST_WR;
            end
          end else if (w_expire_c) begin
            r_req      <= '0;
            r_state    <= ST_ERR;
            r_error    <= 1'b1;
            r_err_idx  <= r_idx;
            r_err_code <= ERR_TIMEOUT;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_ERR: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_req   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign reg_req_o  = r_req;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign error_o    = r_error;
  assign err_idx_o  = r_err_idx;
  assign err_code_o = r_err_code;

endmodule
